wr_flit_ingress: RTL

Write-domain ingress stage for the async FIFO. It accepts flits from a router output port over a valid/ready handshake and buffers them in a 2-entry skid buffer. It drives `winc`/`wdata` into the FIFO's write-pointer/full logic and memory, and stalls on `wfull`. It also tracks packet framing and counts written packets. It sits directly upstream of the FIFO write side, in the `wclk` domain.

---
 rtl/wr_flit_ingress.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wr_flit_ingress.sv
// Write-domain ingress for the async FIFO: valid/ready flit intake, 2-entry skid buffer,
// packet framing and tail counting. Optional length check enabled by WR_INGRESS_LENCHK_EN.
module wr_flit_ingress #(
  parameter int DW      = 32,
  parameter int MAX_LEN = 16
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          wfull,
  output logic          winc,
  output logic [DW:0]   wdata,
  output logic [15:0]   pkt_cnt,
  output logic          len_err,
  output logic          busy
);

  if (MAX_LEN < 2 || MAX_LEN > 255) begin : g_max_len_range
    $error("wr_flit_ingress: MAX_LEN must lie in 2..255");
  end

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } flit_t;

`ifdef WR_INGRESS_LENCHK_EN
  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
  localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       violation;
`else
  typedef enum logic [0:0] {IDLE, BODY} state_t;
`endif

  state_t state_q, state_d;
  flit_t  main_q, main_d, skid_q, skid_d, in_flit;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic   acc, push, push_last, in_ready_d;

  assign acc     = in_valid & in_ready;
  assign winc    = main_v_q & ~wfull;
  assign wdata   = main_q;
  assign busy    = (state_q != IDLE) | main_v_q | skid_v_q;
  assign in_flit = '{last: push_last, data: in_data};

  // Framing FSM: decides whether an accepted flit is buffered and what its last bit is.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    push      = acc;
    push_last = in_last;
`ifdef WR_INGRESS_LENCHK_EN
    cnt_d     = cnt_q;
    violation = 1'b0;
`endif
    if (acc) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d = BODY;
`ifdef WR_INGRESS_LENCHK_EN
            cnt_d   = 8'd1;
`endif
          end
        end
        BODY: begin
`ifdef WR_INGRESS_LENCHK_EN
          if (in_last) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q == LAST_CNT) begin
            // Truncate: this flit becomes the tail, the rest of the packet is discarded.
            violation = 1'b1;
            push_last = 1'b1;
            state_d   = DROP;
            cnt_d     = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`else
          if (in_last) state_d = IDLE;
`endif
        end
`ifdef WR_INGRESS_LENCHK_EN
        DROP: begin
          push = 1'b0;
          if (in_last) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Skid buffer: main feeds the FIFO; skid only fills while main is stalled.
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (winc) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (push) begin
        main_d = in_flit;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (push) begin
      if (!main_v_q) begin
        main_d   = in_flit;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_flit;
        skid_v_d = 1'b1;
      end
    end
    in_ready_d = ~skid_v_d;
`ifdef WR_INGRESS_LENCHK_EN
    if (state_d == DROP) in_ready_d = 1'b1;
`endif
  end

  // NOTE: the buffer entries are reset, not just their valid bits, because wdata is the
  // main entry and must read 0 out of reset; state uses non-blocking assignments only.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      in_ready <= 1'b1;
      pkt_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      in_ready <= in_ready_d;
      if (winc && main_q.last) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

`ifdef WR_INGRESS_LENCHK_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt_q   <= 8'd0;
      len_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_err <= violation;
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule
